apb_soc_ctrl: RTL



---
 rtl/apb_soc_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/apb_soc_ctrl.sv
// APB register block exposing MCU build configuration, boot address / fetch enable
// control, and a 64-bit free-running cycle counter with a tear-free high-word shadow.
module apb_soc_ctrl #(
    parameter int unsigned APB_ADDR_WIDTH    = 12,
    parameter logic [31:0] BOOT_ADDR_DEFAULT = 32'h0000_8000,
    parameter int unsigned DATA_RAM_SIZE     = 32768,
    parameter int unsigned INSTR_RAM_SIZE    = 32768,
    parameter bit          USE_ZERO_RISCY    = 1'b0,
    parameter bit          RISCY_RV32F       = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    output logic [31:0]               boot_addr_o,
    output logic                      fetch_enable_o
);

    localparam logic [4:0] OFS_INFO     = 5'h00;
    localparam logic [4:0] OFS_CORE_CFG = 5'h04;
    localparam logic [4:0] OFS_BOOT     = 5'h08;
    localparam logic [4:0] OFS_CTRL     = 5'h0C;
    localparam logic [4:0] OFS_CYC_LO   = 5'h10;
    localparam logic [4:0] OFS_CYC_HI   = 5'h14;
    localparam logic [4:0] OFS_SCRATCH  = 5'h18;

    localparam logic [15:0] DRAM_KB = 16'(DATA_RAM_SIZE / 1024);
    localparam logic [15:0] IRAM_KB = 16'(INSTR_RAM_SIZE / 1024);

    typedef enum logic {IDLE, RESP} state_t;

    state_t      state, state_nxt;
    logic [31:0] boot_addr;
    logic        fetch_en;
    logic [31:0] scratch;
    logic [63:0] cycle_cnt;
    logic [31:0] cyc_hi_shadow;
    logic [31:0] rdata_p1;
    logic        rerr_p1;

    logic [4:0]  ofs;
    logic        upper_zero;
    logic        aligned;
    logic        rd_start;
    logic        wr_en;
    logic        wr_ok;
    logic        hit;
    logic        ro;
    logic        rd_err;
    logic        wr_err;
    logic [31:0] rd_val;

    assign ofs        = PADDR[4:0];
    assign upper_zero = (PADDR[APB_ADDR_WIDTH-1:5] == '0);
    assign aligned    = (ofs[1:0] == 2'b00);
    assign rd_start   = (state == IDLE) & PSEL & PENABLE & ~PWRITE;
    assign wr_en      = (state == IDLE) & PSEL & PENABLE & PWRITE;
    assign wr_ok      = wr_en & ~wr_err;

    always_comb begin
        hit    = 1'b0;
        ro     = 1'b0;
        rd_val = 32'h0;
        case (ofs)
            OFS_INFO:     begin hit = 1'b1; ro = 1'b1; rd_val = {DRAM_KB, IRAM_KB}; end
            OFS_CORE_CFG: begin hit = 1'b1; ro = 1'b1; rd_val = {30'h0, RISCY_RV32F, USE_ZERO_RISCY}; end
            OFS_BOOT:     begin hit = 1'b1; rd_val = boot_addr; end
            OFS_CTRL:     begin hit = 1'b1; rd_val = {31'h0, fetch_en}; end
            OFS_CYC_LO:   begin hit = 1'b1; ro = 1'b1; rd_val = cycle_cnt[31:0]; end
            OFS_CYC_HI:   begin hit = 1'b1; ro = 1'b1; rd_val = cyc_hi_shadow; end
            OFS_SCRATCH:  begin hit = 1'b1; rd_val = scratch; end
            default:      begin hit = 1'b0; end
        endcase
        rd_err = ~(upper_zero & aligned & hit);
        wr_err = rd_err | ro;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rd_start) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            boot_addr <= BOOT_ADDR_DEFAULT;
            fetch_en  <= 1'b0;
            scratch   <= 32'h0;
        end else if (wr_ok) begin
            case (ofs)
                OFS_BOOT:    boot_addr <= {PWDATA[31:2], 2'b00};
                OFS_CTRL:    fetch_en  <= PWDATA[0];
                OFS_SCRATCH: scratch   <= PWDATA;
                default:     ;
            endcase
        end
    end

    // Clear takes priority over the increment on the write edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= 64'h0;
        end else if (wr_ok && (ofs == OFS_CTRL) && PWDATA[1]) begin
            cycle_cnt <= 64'h0;
        end else begin
            cycle_cnt <= cycle_cnt + 64'd1;
        end
    end

    // Read capture stage: data, error and high-word shadow sampled together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_p1      <= 32'h0;
            rerr_p1       <= 1'b0;
            cyc_hi_shadow <= 32'h0;
        end else if (rd_start) begin
            rdata_p1 <= rd_err ? 32'h0 : rd_val;
            rerr_p1  <= rd_err;
            if (!rd_err && (ofs == OFS_CYC_LO)) begin
                cyc_hi_shadow <= cycle_cnt[63:32];
            end
        end else if (state == RESP) begin
            rdata_p1 <= 32'h0;
            rerr_p1  <= 1'b0;
        end
    end

    assign PRDATA         = rdata_p1;
    assign PREADY         = (state == RESP) | wr_en;
    assign PSLVERR        = (state == RESP) ? rerr_p1 : (wr_en & wr_err);
    assign boot_addr_o    = boot_addr;
    assign fetch_enable_o = fetch_en;

endmodule
